// File: rtl/riscv_reg_checker.sv
// Post-run register-file checker: lets a core run for a programmed number of cycles,
// then scans its register file and compares each checked entry with an expected table.
module riscv_reg_checker #(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  parameter int  CYC_W    = 16,
  parameter int  RD_LAT   = 0,
  localparam int RID_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exp_we,
  input  logic [RID_W-1:0] exp_addr,
  input  logic [XLEN-1:0]  exp_data,
  input  logic             exp_chk,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  output logic             core_run,
  output logic [RID_W-1:0] reg_out_id,
  input  logic [XLEN-1:0]  reg_out_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       fail_count,
  output logic [RID_W-1:0] first_fail_id,
  output logic [XLEN-1:0]  first_fail_data
);

  localparam int          IDX_W      = 6;
  localparam logic [IDX_W-1:0] NUM_REGS_L = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] SCAN_LAST  = IDX_W'(NUM_REGS + RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [5:0]           fail_q, fail_d;
  logic [RID_W-1:0]     ffid_q, ffid_d;
  logic [XLEN-1:0]      ffdata_q, ffdata_d;
  logic [NUM_REGS-1:0]  chk_q, chk_d;
  logic [XLEN-1:0]      exp_mem [NUM_REGS];

  logic                 ready;
  logic                 go;
  logic                 wr_en;
  logic                 cmp_vld;
  logic [RID_W-1:0]     cmp_id;
  logic                 mismatch;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign go    = ready && start;
  assign wr_en = ready && exp_we && ({1'b0, exp_addr} < NUM_REGS_L);

  // The entry under comparison trails the presented read index by the read latency
  assign cmp_id   = idx_q[RID_W-1:0] - RID_W'(RD_LAT);
  assign cmp_vld  = (state_q == S_SCAN) && ((RD_LAT == 0) || (idx_q != '0));
  assign mismatch = cmp_vld && chk_q[cmp_id] && (reg_out_data != exp_mem[cmp_id]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      fail_q   <= '0;
      ffid_q   <= '0;
      ffdata_q <= '0;
      chk_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      ffid_q   <= ffid_d;
      ffdata_q <= ffdata_d;
      chk_q    <= chk_d;
    end
  end

  // Expected values carry no reset; their check bits gate every use
  always_ff @(posedge clock) begin
    if (wr_en) exp_mem[exp_addr] <= exp_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (run_cycles == '0) ? S_SCAN : S_RUN;
      end
      S_RUN: begin
        if (cnt_q <= CYC_W'(1)) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (idx_q == SCAN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    ffid_d   = ffid_q;
    ffdata_d = ffdata_q;
    chk_d    = chk_q;
    if (wr_en) chk_d[exp_addr] = exp_chk;
    if (go) begin
      cnt_d    = run_cycles;
      idx_d    = '0;
      fail_d   = '0;
      ffid_d   = '0;
      ffdata_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - CYC_W'(1);
    end else if (state_q == S_SCAN) begin
      idx_d = idx_q + IDX_W'(1);
      if (mismatch) begin
        fail_d = sat_inc6(fail_q);
        if (fail_q == '0) begin
          ffid_d   = cmp_id;
          ffdata_d = reg_out_data;
        end
      end
    end
  end

  always_comb begin
    core_run   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    reg_out_id = '0;
    case (state_q)
      S_RUN: begin
        core_run = 1'b1;
        busy     = 1'b1;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (idx_q < NUM_REGS_L) reg_out_id = idx_q[RID_W-1:0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass            = done && (fail_q == '0);
  assign fail_count      = fail_q;
  assign first_fail_id   = ffid_q;
  assign first_fail_data = ffdata_q;

endmodule

// File: tb/tb_riscv_reg_checker.sv
// Bench for riscv_reg_checker: one instance with a combinational register file,
// one with a registered register file, both driven with the same control inputs.
module tb_riscv_reg_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        exp_we, exp_chk, start;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [15:0] run_cycles;

  logic        core_run0, busy0, done0, pass0;
  logic [4:0]  id0, ffid0;
  logic [31:0] rdata0, ffd0;
  logic [5:0]  fc0;
  logic        core_run1, busy1, done1, pass1;
  logic [4:0]  id1, ffid1;
  logic [31:0] rdata1, ffd1;
  logic [5:0]  fc1;

  logic [31:0] rf    [32];
  logic [31:0] m_exp [32];
  bit          m_chk [32];
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [43:0] res0, res1;
  localparam logic [43:0] RES_PASS = {1'b1, 6'd0, 5'd0, 32'd0};

  assign res0   = {pass0, fc0, ffid0, ffd0};
  assign res1   = {pass1, fc1, ffid1, ffd1};
  assign rdata0 = rf[id0];
  always @(posedge clock) rdata1 <= rf[id1];
  always #5 clock = ~clock;

  riscv_reg_checker #(.XLEN(32), .NUM_REGS(32), .CYC_W(16), .RD_LAT(0)) dut0 (
    .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_chk(exp_chk), .start(start), .run_cycles(run_cycles), .core_run(core_run0),
    .reg_out_id(id0), .reg_out_data(rdata0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_id(ffid0), .first_fail_data(ffd0));

  riscv_reg_checker #(.XLEN(32), .NUM_REGS(32), .CYC_W(16), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_chk(exp_chk), .start(start), .run_cycles(run_cycles), .core_run(core_run1),
    .reg_out_id(id1), .reg_out_data(rdata1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_id(ffid1), .first_fail_data(ffd1));

  // Expected outcome straight from the rules: count checked entries whose value differs.
  function automatic logic [43:0] model_result();
    int          cnt = 0;
    int          fid = 0;
    logic [31:0] fd  = '0;
    for (int i = 0; i < 32; i++) begin
      if (m_chk[i] && rf[i] != m_exp[i]) begin
        if (cnt == 0) begin
          fid = i;
          fd  = rf[i];
        end
        cnt++;
      end
    end
    if (cnt > 63) cnt = 63;
    return {cnt == 0, 6'(cnt), 5'(fid), fd};
  endfunction

  // All helpers start and end right after a falling edge.
  task automatic write_entry(input int addr, input logic [31:0] data, input bit chk);
    exp_we = 1'b1; exp_addr = 5'(addr); exp_data = data; exp_chk = chk;
    @(negedge clock);
    exp_we = 1'b0;
    m_exp[addr] = data;
    m_chk[addr] = chk;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) write_entry(i, 32'd0, 1'b0);
  endtask

  task automatic load_random_table();
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      if ($urandom_range(0, 1) == 0) write_entry(i, rf[i], 1'($urandom_range(0, 1)));
      else write_entry(i, rf[i] ^ (32'd1 << $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_measure(input logic [15:0] rc, input bit core_wr, input bit disturb,
                             output int cr0, output int cr1, output int sc0, output int sc1,
                             output int id_bad, output bit first_busy, output bit first_cr,
                             output bit tmo);
    cr0 = 0; cr1 = 0; sc0 = 0; sc1 = 0; id_bad = 0; first_busy = 0; first_cr = 0;
    start = 1'b1; run_cycles = rc;
    @(negedge clock);
    start = 1'b0; exp_we = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k == 0) begin
        first_busy = busy0;
        first_cr   = core_run0;
      end
      if (core_run0) cr0++;
      if (core_run1) cr1++;
      if (busy0 && !core_run0) sc0++;
      if (busy1 && !core_run1) sc1++;
      else if (id1 != 5'd0) id_bad++;
      if (!(busy0 && !core_run0) && id0 != 5'd0) id_bad++;
      if (done0 && done1) break;
      start = 1'b0; exp_we = 1'b0;
      if (core_wr && core_run0) rf[10] = 32'd3;
      if (disturb && core_run0) begin
        exp_we = 1'b1; exp_addr = 5'd7; exp_data = ~rf[7]; exp_chk = 1'b1;
      end
      if (disturb && busy0 && !core_run0 && sc0 == 3) start = 1'b1;
      @(negedge clock);
    end
    start = 1'b0; exp_we = 1'b0;
    tmo = !(done0 && done1);
  endtask

  task automatic test_reset();
    reset = 1'b1; exp_we = 0; exp_chk = 0; start = 0; exp_addr = 0; exp_data = 0; run_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom; m_exp[i] = 0; m_chk[i] = 0;
    end
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({core_run0, busy0, done0, res0, id0} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: got %h want 0", {core_run0, busy0, done0, res0, id0});
    end
    n_cmp++;
    if ({core_run1, busy1, done1, res1, id1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %h want 0", {core_run1, busy1, done1, res1, id1});
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({core_run0, busy0, done0} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 000", {core_run0, busy0, done0});
    end
  endtask

  task automatic test_addi();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    clear_table();
    rf[10] = 32'd0; rf[0] = 32'd0;
    write_entry(10, 32'd3, 1'b1);
    write_entry(0, 32'd0, 1'b1);
    run_measure(16'd20, 1'b1, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    n_cmp++;
    if (tmo || cr0 != 20 || cr1 != 20) begin
      n_fail++; $display("FAIL addi_core_run: got %0d/%0d tmo=%0d want 20", cr0, cr1, tmo);
    end
    n_cmp++;
    if (res0 !== RES_PASS || res1 !== RES_PASS) begin
      n_fail++; $display("FAIL addi_result: got %h/%h want %h", res0, res1, RES_PASS);
    end
  endtask

  task automatic test_mismatch();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    logic [43:0] want;
    want = {1'b0, 6'd2, 5'd2, 32'd4};
    clear_table();
    write_entry(2, 32'd5, 1'b1);
    write_entry(5, 32'd7, 1'b1);
    rf[2] = 32'd4; rf[5] = 32'd0;
    run_measure(16'd3, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    n_cmp++;
    if (tmo || res0 !== want) begin
      n_fail++; $display("FAIL mismatch_dut0: got %h want %h", res0, want);
    end
    n_cmp++;
    if (tmo || res1 !== want) begin
      n_fail++; $display("FAIL mismatch_dut1: got %h want %h", res1, want);
    end
  endtask

  task automatic test_zero_cycles();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      if ($urandom_range(0, 1) == 1) write_entry(i, rf[i], 1'b1);
      else write_entry(i, ~rf[i], 1'b0);
    end
    run_measure(16'd0, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    n_cmp++;
    if (fb !== 1'b1 || fc !== 1'b0 || cr0 != 0 || cr1 != 0) begin
      n_fail++; $display("FAIL zero_cycles_timing: got busy=%0d run=%0d cr=%0d/%0d want 1 0 0 0",
                         fb, fc, cr0, cr1);
    end
    n_cmp++;
    if (tmo || sc0 != 32 || sc1 != 33) begin
      n_fail++; $display("FAIL zero_cycles_scan_len: got %0d/%0d want 32/33", sc0, sc1);
    end
    n_cmp++;
    if (res0 !== RES_PASS || res1 !== RES_PASS) begin
      n_fail++; $display("FAIL zero_cycles_unchecked: got %h/%h want %h", res0, res1, RES_PASS);
    end
  endtask

  task automatic test_back_to_back();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    logic [43:0] want;
    // Table write lands in the same cycle as start from DONE
    exp_we = 1'b1; exp_addr = 5'd3; exp_data = ~rf[3]; exp_chk = 1'b1;
    m_exp[3] = ~rf[3]; m_chk[3] = 1'b1;
    run_measure(16'd4, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    want = model_result();
    n_cmp++;
    if (tmo || cr0 != 4 || res0 !== want) begin
      n_fail++; $display("FAIL back_to_back_dut0: got %h cr=%0d want %h cr=4", res0, cr0, want);
    end
    n_cmp++;
    if (tmo || res1 !== want) begin
      n_fail++; $display("FAIL back_to_back_dut1: got %h want %h", res1, want);
    end
  endtask

  task automatic test_random();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    logic [15:0] rc;
    logic [43:0] want;
    for (int it = 0; it < 4; it++) begin
      load_random_table();
      rc = 16'($urandom_range(1, 25));
      run_measure(rc, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
      want = model_result();
      n_cmp++;
      if (tmo || cr0 != int'(rc) || cr1 != int'(rc) || sc0 != 32 || sc1 != 33) begin
        n_fail++; $display("FAIL random_timing[%0d]: got cr=%0d/%0d scan=%0d/%0d want cr=%0d scan=32/33",
                           it, cr0, cr1, sc0, sc1, rc);
      end
      n_cmp++;
      if (idb != 0) begin
        n_fail++; $display("FAIL random_idle_id[%0d]: got %0d nonzero ids want 0", it, idb);
      end
      n_cmp++;
      if (res0 !== want || res1 !== want) begin
        n_fail++; $display("FAIL random_result[%0d]: got %h/%h want %h", it, res0, res1, want);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo;
    logic [43:0] want;
    load_random_table();
    write_entry(7, rf[7], 1'b1);
    run_measure(16'd6, 1'b0, 1'b1, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    want = model_result();
    n_cmp++;
    if (tmo || cr0 != 6 || sc0 != 32 || sc1 != 33) begin
      n_fail++; $display("FAIL busy_no_restart: got cr=%0d scan=%0d/%0d want 6 32/33", cr0, sc0, sc1);
    end
    n_cmp++;
    if (res0 !== want || res1 !== want) begin
      n_fail++; $display("FAIL busy_result: got %h/%h want %h", res0, res1, want);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_cmp++;
      if (!done0 || busy0 || id0 != 5'd0 || res0 !== want) begin
        n_fail++; $display("FAIL done_hold[%0d]: got done=%0d res=%h want 1 %h", k, done0, res0, want);
      end
    end
    run_measure(16'd2, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    n_cmp++;
    if (tmo || res0 !== want || res1 !== want) begin
      n_fail++; $display("FAIL busy_table_unchanged: got %h/%h want %h", res0, res1, want);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cr0, cr1, sc0, sc1, idb; bit fb, fc, tmo, hit;
    logic [43:0] want;
    load_random_table();
    start = 1'b1; run_cycles = 16'd2;
    @(negedge clock);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy0 && !core_run0 && id0 == 5'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (!hit) begin
      n_fail++; $display("FAIL mid_scan_reach: got no index 7 want index 7 within 100 cycles");
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({core_run0, busy0, done0, res0, id0, core_run1, busy1, done1, res1, id1} !== '0) begin
      n_fail++; $display("FAIL mid_scan_reset: got %h/%h want 0", {busy0, done0, res0, id0},
                         {busy1, done1, res1, id1});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_chk[i] = 1'b0;
    @(negedge clock);
    run_measure(16'd3, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    n_cmp++;
    if (tmo || cr0 != 3 || sc0 != 32 || res0 !== RES_PASS || res1 !== RES_PASS) begin
      n_fail++; $display("FAIL after_reset_clean: got %h/%h cr=%0d want %h cr=3", res0, res1, cr0, RES_PASS);
    end
    load_random_table();
    run_measure(16'd5, 1'b0, 1'b0, cr0, cr1, sc0, sc1, idb, fb, fc, tmo);
    want = model_result();
    n_cmp++;
    if (tmo || res0 !== want || res1 !== want) begin
      n_fail++; $display("FAIL after_reset_full: got %h/%h want %h", res0, res1, want);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mismatch();
    test_zero_cycles();
    test_back_to_back();
    test_random();
    test_busy_ignore();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
